// File: rtl/rng_sched.sv
// rng_sched: time-shared controller for the 64-bit LFSR generator of the
// rtt_probe datapath.
//   - Round-robin arbitration of draw requests from NUM_REQ clients.
//   - Kicks the generator and waits SETTLE cycles for its 64-shift run.
//   - Returns the settled value with a one-cycle, one-hot grant.
//   - Serialises seed writes so they land only while the generator is idle.
//
// Ports:
//   clk, reset_n       clock / async active-low reset
//   req[NUM_REQ]       level draw requests
//   gnt[NUM_REQ]       one-hot grant pulse, data valid in the same cycle
//   data[64]           last drawn value, held until the next grant
//   seed_req, seed_in  level reseed request and its 32-bit seed
//   seed_ack           pulse in the cycle the seed is written
//   rng_seed_wr, rng_seed, rng_kick   generator controls
//   rng_out[64]        generator output
//
// All outputs are registered.
module rng_sched #(
  parameter int NUM_REQ = 4,
  parameter int SETTLE  = 65
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [63:0]        data,
  input  logic               seed_req,
  input  logic [31:0]        seed_in,
  output logic               seed_ack,
  output logic               rng_seed_wr,
  output logic [31:0]        rng_seed,
  output logic               rng_kick,
  input  logic [63:0]        rng_out
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SEED, ST_WAIT} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        ptr, ptr_n;
  logic [IW-1:0]        win, win_n;
  logic [IW-1:0]        pick;
  logic [NUM_REQ-1:0]   gnt_n;
  logic [63:0]          data_n;
  logic                 ack_n, swr_n, kick_n;
  logic [31:0]          seed_n;

  // Round-robin pick: first set request scanning upward from ptr, wrapping.
  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IW'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    win_n   = win;
    gnt_n   = '0;
    data_n  = data;
    ack_n   = 1'b0;
    swr_n   = 1'b0;
    seed_n  = rng_seed;
    kick_n  = 1'b0;
    case (state)
      // Wake-up draw with no winner. The counter starts at 0 in the first
      // cycle out of reset, so the kick is visible in cycle 1 and IDLE is
      // entered in cycle SETTLE+1.
      ST_INIT: begin
        kick_n = (cnt == '0);
        if (cnt == CW'(SETTLE)) state_n = ST_IDLE;
        else                    cnt_n   = cnt + 1'b1;
      end
      ST_IDLE: begin
        if (seed_req) begin
          seed_n  = seed_in;
          swr_n   = 1'b1;
          ack_n   = 1'b1;
          state_n = ST_SEED;
        end else if (|req) begin
          win_n   = pick;
          kick_n  = 1'b1;
          cnt_n   = '0;
          state_n = ST_WAIT;
        end
      end
      // Seed write is on the outputs this cycle; seed_req is not looked at.
      ST_SEED: state_n = ST_IDLE;
      ST_WAIT: begin
        if (cnt == CW'(SETTLE)) begin
          data_n  = rng_out;
          gnt_n   = NUM_REQ'(1) << win;
          ptr_n   = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_INIT;
      cnt         <= '0;
      ptr         <= '0;
      win         <= '0;
      gnt         <= '0;
      data        <= '0;
      seed_ack    <= 1'b0;
      rng_seed_wr <= 1'b0;
      rng_seed    <= '0;
      rng_kick    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      ptr         <= ptr_n;
      win         <= win_n;
      gnt         <= gnt_n;
      data        <= data_n;
      seed_ack    <= ack_n;
      rng_seed_wr <= swr_n;
      rng_seed    <= seed_n;
      rng_kick    <= kick_n;
    end
  end

endmodule

// File: tb/tb_rng_sched.sv
// Self-checking bench for rng_sched: behavioural generator stub plus a
// transaction-level reference (RR pointer, expected generator value).
module tb_rng_sched;
  localparam int N      = 4;
  localparam int SETTLE = 65;
  localparam int LAT    = SETTLE + 2;
  localparam logic [63:0] GEN_INIT = 64'hDEAD_BEEF_CAFE_F00D;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  gnt;
  logic [63:0]   data;
  logic          seed_req = 1'b0;
  logic [31:0]   seed_in = '0;
  logic          seed_ack, rng_seed_wr, rng_kick;
  logic [31:0]   rng_seed;
  logic [63:0]   rng_out;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  rng_sched #(.NUM_REQ(N), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .gnt(gnt), .data(data),
    .seed_req(seed_req), .seed_in(seed_in), .seed_ack(seed_ack),
    .rng_seed_wr(rng_seed_wr), .rng_seed(rng_seed), .rng_kick(rng_kick),
    .rng_out(rng_out)
  );

  function automatic logic [63:0] lfsr(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) v = {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Generator stub: seed write loads {seed,seed}; kick restarts a 64-shift run.
  logic [63:0] gst = GEN_INIT;
  int          gcnt = 64;
  assign rng_out = gst;
  always @(posedge clk) begin
    if (rng_seed_wr)    gst <= {rng_seed, rng_seed};
    else if (gcnt < 64) gst <= lfsr(gst, 1);
    if (rng_kick)       gcnt <= 0;
    else if (gcnt < 64) gcnt <= gcnt + 1;
  end

  // Cycle n = after the n-th rising edge since reset release.
  int cyc;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0; else cyc <= cyc + 1;

  int kick_q[$];
  int last_kick = -1000;
  int last_ack  = -1;
  int gnt_seen  = 0;
  always @(negedge clk) begin
    if (!reset_n) last_kick = -1000;
    else begin
      if (rng_kick) begin last_kick = cyc; kick_q.push_back(cyc); end
      if (seed_ack) last_ack = cyc;
      if (rng_seed_wr) chk("seed_wr_vs_shift", 64'(cyc - last_kick > 64), 64'(1));
      if (gnt != '0) begin gnt_seen++; chk("gnt_onehot", 64'($onehot(gnt)), 64'(1)); end
    end
  end

  // Reference state
  int          ptr_m;
  logic [63:0] ref_st;
  bit          ref_ok;

  function automatic int pick(input logic [N-1:0] m, input int p);
    logic [N-1:0] t;
    for (int i = 0; i < N; i++) begin
      t = m >> ((p + i) % N);
      if (t[0]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_gnt"},  64'(gnt), 64'(0));
    chk({tag, "_data"}, data, 64'(0));
    chk({tag, "_ack"},  64'(seed_ack), 64'(0));
    chk({tag, "_swr"},  64'(rng_seed_wr), 64'(0));
    chk({tag, "_seed"}, 64'(rng_seed), 64'(0));
    chk({tag, "_kick"}, 64'(rng_kick), 64'(0));
  endtask

  task automatic wait_gnt(input int lim, output int c);
    c = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (gnt != '0) begin c = cyc; break; end
    end
    if (c < 0) chk("gnt_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_ack(input int lim, output int c);
    c = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (seed_ack) begin c = cyc; break; end
    end
    if (c < 0) chk("ack_timeout", 64'(0), 64'(1));
  endtask

  task automatic finish_draw(input string tag, input int c, input int exp_c, input int w);
    chk({tag, "_lat"}, 64'(c), 64'(exp_c));
    chk({tag, "_gnt"}, 64'(gnt), 64'(1 << w));
    ref_st = lfsr(ref_st, 64);
    if (ref_ok) chk({tag, "_data"}, data, ref_st);
    ptr_m = (w + 1) % N;
  endtask

  // Called at a negedge while the DUT is idle; returns at the gnt negedge.
  task automatic do_draw(input logic [N-1:0] m);
    int d, c, w;
    d = cyc; req = m; w = pick(m, ptr_m);
    wait_gnt(LAT + 10, c);
    finish_draw("draw", c, d + LAT, w);
    req = '0;
  endtask

  // Returns at the negedge of the first idle cycle after the seed write.
  task automatic do_seed(input logic [31:0] v);
    int d, c;
    d = cyc; seed_req = 1'b1; seed_in = v;
    wait_ack(10, c);
    chk("seed_lat", 64'(c), 64'(d + 1));
    chk("seed_val", 64'(rng_seed), 64'(v));
    chk("seed_wr",  64'(rng_seed_wr), 64'(1));
    seed_req = 1'b0;
    ref_st = {v, v}; ref_ok = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int c, d, w, prev;
    logic [N-1:0] m;
    logic [31:0]  v;

    // Reset and an idle wake-up draw
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    kick_q.delete(); gnt_seen = 0;
    ref_st = lfsr(GEN_INIT, 64); ref_ok = 1'b1; ptr_m = 0;
    reset_n = 1'b1;
    repeat (140) @(negedge clk);
    chk("init_kick_count", 64'(kick_q.size()), 64'(1));
    chk("init_kick_cycle", 64'(kick_q[0]), 64'(1));
    chk("init_no_gnt", 64'(gnt_seen), 64'(0));

    // Reset again with all clients holding req: first IDLE at SETTLE+1,
    // then back-to-back grants 0,1,2,3,0.
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    req = 4'b1111; ptr_m = 0;
    ref_st = lfsr(ref_st, 64);
    reset_n = 1'b1;
    prev = SETTLE + 1;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(LAT + SETTLE + 10, c);
      finish_draw("rr", c, prev + LAT, k % N);
      prev = c;
    end
    req = '0;

    // Zero seed locks the generator at zero
    do_seed(32'h0);
    do_draw(4'b0001);
    chk("zero_seed_data", data, 64'h0);

    // Known seed, client 2
    do_seed(32'h1234_5678);
    do_draw(4'b0100);
    chk("seed_1234_data", data, lfsr(64'h1234_5678_1234_5678, 64));

    // Seed request raised mid-draw waits for the grant
    m = 4'b1001; d = cyc; req = m; w = pick(m, ptr_m); last_ack = -1;
    v = $urandom;
    repeat (20) @(negedge clk);
    seed_req = 1'b1; seed_in = v;
    wait_gnt(LAT + 10, c);
    finish_draw("wait_seed", c, d + LAT, w);
    req = '0;
    chk("no_ack_during_wait", 64'(last_ack), 64'(-1));
    prev = c;
    wait_ack(10, c);
    chk("ack_after_gnt", 64'(c), 64'(prev + 1));
    chk("ack_seed_val", 64'(rng_seed), 64'(v));
    seed_req = 1'b0; ref_st = {v, v};
    @(negedge clk);

    // Randomised mix of seeds, draws and simultaneous seed+draw
    for (int it = 0; it < 16; it++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      case ($urandom_range(0, 2))
        0: do_seed($urandom);
        1: do_draw(N'($urandom_range(1, 15)));
        default: begin
          m = N'($urandom_range(1, 15)); v = $urandom;
          d = cyc; seed_req = 1'b1; seed_in = v; req = m;
          wait_ack(10, c);
          chk("both_ack_lat", 64'(c), 64'(d + 1));
          seed_req = 1'b0; ref_st = {v, v}; ref_ok = 1'b1;
          w = pick(m, ptr_m);
          wait_gnt(LAT + 10, c);
          finish_draw("both", c, d + 2 + LAT, w);
          req = '0;
        end
      endcase
    end

    // Reset during WAIT counter 30: outputs clear at once, INIT repeats
    do_seed(32'hA5A5_0F0F);
    m = 4'b0010; d = cyc; req = m;
    repeat (31) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_reset_outs("async_rst");
    repeat (3) @(negedge clk);
    gnt_seen = 0; ptr_m = 0; ref_ok = 1'b0;
    reset_n = 1'b1;
    wait_gnt(LAT + SETTLE + 10, c);
    finish_draw("post_rst", c, SETTLE + 1 + LAT, 1);
    req = '0;
    @(negedge clk);
    chk("post_rst_single_gnt", 64'(gnt_seen), 64'(1));
    do_seed($urandom);
    do_draw(N'($urandom_range(1, 15)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
